// File: rtl/ts_checker.sv
// MPEG-TS sync/lock tracker with header parse and PID statistics.
// Counts packets, continuity errors and missed syncs for one PID.
module ts_checker #(
  parameter int PKT_LEN    = 188,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA,
  input  logic        D_VALID,
  input  logic        P_SYNC,
  input  logic [12:0] PID_FILTER,
  input  logic        CLR_CNT,
  output logic        LOCKED,
  output logic        HDR_VALID,
  output logic [12:0] LAST_PID,
  output logic [3:0]  LAST_CC,
  output logic [15:0] PKT_CNT,
  output logic [15:0] CC_ERR_CNT,
  output logic [15:0] SYNC_ERR_CNT
);

  localparam int IW = (PKT_LEN > 4) ? $clog2(PKT_LEN) : 2;
  localparam logic [IW-1:0] ILAST  = IW'(PKT_LEN - 1);
  localparam logic [7:0]    LOCK_T = 8'(LOCK_CNT);
  localparam logic [7:0]    MISS_T = 8'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d, idx_nxt;
  logic [7:0]    good_q, good_d;
  logic [7:0]    miss_q, miss_d;
  logic          sync_ok, at_zero;
  logic          miss_evt, lock_entry;
  logic          locked;

  logic [4:0]    pid_hi_q;
  logic [7:0]    pid_lo_q;
  logic [12:0]   pid_cur;
  logic [12:0]   pid_flt_q;
  logic          hdr_evt, pid_match;
  logic          filt_chg, cc_bad;
  logic [3:0]    cc_prev_q;
  logic          cc_valid_q;

  logic          hdr_valid_q;
  logic [12:0]   last_pid_q;
  logic [3:0]    last_cc_q;
  logic [15:0]   pkt_cnt_q;
  logic [15:0]   cc_err_cnt_q;
  logic [15:0]   sync_err_cnt_q;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign sync_ok = P_SYNC && (DATA == 8'h47);
  assign at_zero = (idx_q == '0);
  assign idx_nxt = (idx_q == ILAST) ? '0
                                    : idx_q + IW'(1);

  // State, byte index and good/miss run counters
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= HUNT;
      idx_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state: acquire, verify and hold packet alignment
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    good_d   = good_q;
    miss_d   = miss_q;
    miss_evt = 1'b0;
    if (D_VALID) begin
      unique case (state_q)
        HUNT: begin
          if (sync_ok) begin
            idx_d   = IW'(1);
            good_d  = 8'd1;
            miss_d  = '0;
            state_d = (good_d >= LOCK_T) ? LOCK
                                         : VERIFY;
          end
        end
        VERIFY: begin
          idx_d = idx_nxt;
          if (at_zero) begin
            if (sync_ok) begin
              good_d = good_q + 8'd1;
              if (good_d >= LOCK_T) begin
                state_d = LOCK;
                miss_d  = '0;
              end
            end else begin
              state_d = HUNT;
              good_d  = '0;
              idx_d   = '0;
            end
          end
        end
        LOCK: begin
          idx_d = idx_nxt;
          if (at_zero) begin
            if (sync_ok) begin
              miss_d = '0;
            end else begin
              miss_evt = 1'b1;
              miss_d   = miss_q + 8'd1;
              if (miss_d >= MISS_T) begin
                state_d = HUNT;
                idx_d   = '0;
                good_d  = '0;
                miss_d  = '0;
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = '0;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // Lock indication follows the registered state
  always_comb begin
    locked = (state_q == LOCK);
  end

  assign lock_entry = (state_d == LOCK) &&
                      (state_q != LOCK);

  assign hdr_evt   = D_VALID && locked &&
                     (idx_q == IW'(3));
  assign pid_cur   = {pid_hi_q, pid_lo_q};
  assign pid_match = (pid_cur == PID_FILTER);
  assign filt_chg  = (PID_FILTER != pid_flt_q);
  assign cc_bad    = cc_valid_q && !filt_chg &&
                     (DATA[3:0] != cc_prev_q + 4'd1);

  // Header field capture and last-header reporting
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pid_hi_q    <= '0;
      pid_lo_q    <= '0;
      hdr_valid_q <= 1'b0;
      last_pid_q  <= '0;
      last_cc_q   <= '0;
    end else begin
      hdr_valid_q <= hdr_evt;
      if (D_VALID && locked) begin
        if (idx_q == IW'(1)) pid_hi_q <= DATA[4:0];
        if (idx_q == IW'(2)) pid_lo_q <= DATA;
      end
      if (hdr_evt) begin
        last_pid_q <= pid_cur;
        last_cc_q  <= DATA[3:0];
      end
    end
  end

  // Continuity reference for the filtered PID
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pid_flt_q  <= '0;
      cc_prev_q  <= '0;
      cc_valid_q <= 1'b0;
    end else begin
      pid_flt_q <= PID_FILTER;
      if (CLR_CNT) begin
        cc_valid_q <= 1'b0;
      end else if (hdr_evt && pid_match) begin
        cc_prev_q  <= DATA[3:0];
        cc_valid_q <= 1'b1;
      end else if (filt_chg || lock_entry) begin
        cc_valid_q <= 1'b0;
      end
    end
  end

  // Saturating statistics; clear wins over increments
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pkt_cnt_q      <= '0;
      cc_err_cnt_q   <= '0;
      sync_err_cnt_q <= '0;
    end else if (CLR_CNT) begin
      pkt_cnt_q      <= '0;
      cc_err_cnt_q   <= '0;
      sync_err_cnt_q <= '0;
    end else begin
      if (hdr_evt && pid_match)
        pkt_cnt_q <= sat_inc(pkt_cnt_q);
      if (hdr_evt && pid_match && cc_bad)
        cc_err_cnt_q <= sat_inc(cc_err_cnt_q);
      if (miss_evt)
        sync_err_cnt_q <= sat_inc(sync_err_cnt_q);
    end
  end

  assign LOCKED       = locked;
  assign HDR_VALID    = hdr_valid_q;
  assign LAST_PID     = last_pid_q;
  assign LAST_CC      = last_cc_q;
  assign PKT_CNT      = pkt_cnt_q;
  assign CC_ERR_CNT   = cc_err_cnt_q;
  assign SYNC_ERR_CNT = sync_err_cnt_q;

endmodule

// File: tb/tb_ts_checker.sv
// Bench for ts_checker: directed TS streams with a header scoreboard.
// Expected header reports are queued by stimulus and popped on HDR_VALID.
module tb_ts_checker;

  localparam int PKT = 188;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        d_valid;
  logic        p_sync;
  logic [12:0] pid_filter;
  logic        clr_cnt;
  logic        locked;
  logic        hdr_valid;
  logic [12:0] last_pid;
  logic [3:0]  last_cc;
  logic [15:0] pkt_cnt;
  logic [15:0] cc_err_cnt;
  logic [15:0] sync_err_cnt;

  typedef struct packed {
    logic [12:0] pid;
    logic [3:0]  cc;
    logic [15:0] pkt;
    logic [15:0] cce;
    logic [15:0] se;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ep, ee, es;
  logic [3:0] cc;

  ts_checker #(
    .PKT_LEN(PKT),
    .LOCK_CNT(3),
    .UNLOCK_CNT(3)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .DATA(data),
    .D_VALID(d_valid),
    .P_SYNC(p_sync),
    .PID_FILTER(pid_filter),
    .CLR_CNT(clr_cnt),
    .LOCKED(locked),
    .HDR_VALID(hdr_valid),
    .LAST_PID(last_pid),
    .LAST_CC(last_cc),
    .PKT_CNT(pkt_cnt),
    .CC_ERR_CNT(cc_err_cnt),
    .SYNC_ERR_CNT(sync_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic void push(
    input logic [12:0] pid,
    input logic [3:0]  c
  );
    exp_t e;
    e.pid = pid;
    e.cc  = c;
    e.pkt = 16'(ep);
    e.cce = 16'(ee);
    e.se  = 16'(es);
    q.push_back(e);
  endfunction

  // Monitor: every header pulse must match a queued expectation
  always @(negedge clk) begin
    if (hdr_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL hdr_unexpected: got pulse expected none @%0t",
                 $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("last_pid", 32'(last_pid), 32'(e.pid));
        chk("last_cc", 32'(last_cc), 32'(e.cc));
        chk("pkt_cnt", 32'(pkt_cnt), 32'(e.pkt));
        chk("cc_err_cnt", 32'(cc_err_cnt), 32'(e.cce));
        chk("sync_err_cnt", 32'(sync_err_cnt), 32'(e.se));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [12:0] pid,
    input logic [3:0]  c,
    input logic [7:0]  sb,
    input bit          gaps,
    input bit          fake,
    input bit          clr4,
    input int          nb
  );
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        repeat ($urandom_range(3, 1)) begin
          d_valid = 1'b0;
          data    = 8'h47;
          p_sync  = 1'b1;
          clr_cnt = 1'b0;
          step();
        end
      end
      d_valid = 1'b1;
      p_sync  = (i == 0);
      clr_cnt = clr4 && (i == 4);
      if (i == 0)      data = sb;
      else if (i == 1) data = {3'b000, pid[12:8]};
      else if (i == 2) data = pid[7:0];
      else if (i == 3) data = {4'h0, c};
      else             data = 8'(i);
      if (fake && i == 100) begin
        data   = 8'h47;
        p_sync = 1'b1;
      end
      step();
    end
    d_valid = 1'b0;
    p_sync  = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_locked"}, 32'(locked), 0);
    chk({nm, "_hdr"}, 32'(hdr_valid), 0);
    chk({nm, "_lpid"}, 32'(last_pid), 0);
    chk({nm, "_lcc"}, 32'(last_cc), 0);
    chk({nm, "_pkt"}, 32'(pkt_cnt), 0);
    chk({nm, "_cce"}, 32'(cc_err_cnt), 0);
    chk({nm, "_se"}, 32'(sync_err_cnt), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    d_valid    = 1'b0;
    data       = 8'h00;
    p_sync     = 1'b0;
    pid_filter = 13'h100;
    clr_cnt    = 1'b0;
    ep = 0; ee = 0; es = 0;
    cc = 4'd0;
    repeat (3) step();
    chk_zero("rst");
    rst_n = 1'b1;
    step();

    // Clean stream: lock on third sync, CC wraps 15->0
    for (int k = 0; k < 20; k++) begin
      if (k >= 2) begin
        ep++;
        push(13'h100, cc);
      end
      send(13'h100, cc, 8'h47, 0, k >= 3, 0, PKT);
      cc++;
      if (k < 2)
        chk("locked_pre", 32'(locked), 0);
      else if (k == 2)
        chk("locked_post", 32'(locked), 1);
    end

    // One CC jump by two, then continuity resumes
    cc++;
    ep++; ee++;
    push(13'h100, cc);
    send(13'h100, cc, 8'h47, 0, 1, 0, PKT);
    cc++;
    for (int k = 0; k < 2; k++) begin
      ep++;
      push(13'h100, cc);
      send(13'h100, cc, 8'h47, 0, 1, 0, PKT);
      cc++;
    end

    // Idle gaps inside packets
    for (int k = 0; k < 4; k++) begin
      ep++;
      push(13'h100, cc);
      send(13'h100, cc, 8'h47, 1, 1, 0, PKT);
      cc++;
    end

    // Non-matching filter: headers still reported
    pid_filter = 13'h1FFF;
    for (int k = 0; k < 2; k++) begin
      push(13'h100, cc);
      send(13'h100, cc, 8'h47, 0, 0, 0, PKT);
      cc++;
    end
    chk("flt_pkt", 32'(pkt_cnt), 32'(ep));

    // Filter change invalidates CC reference
    pid_filter = 13'h100;
    cc = cc + 4'd5;
    ep++;
    push(13'h100, cc);
    send(13'h100, cc, 8'h47, 0, 0, 0, PKT);
    cc++;

    // Clear on the header pulse cycle
    ep++;
    push(13'h100, cc);
    send(13'h100, cc, 8'h47, 0, 0, 1, PKT);
    cc++;
    ep = 0; ee = 0; es = 0;
    chk("clr_pkt", 32'(pkt_cnt), 0);
    chk("clr_cce", 32'(cc_err_cnt), 0);
    chk("clr_lpid", 32'(last_pid), 32'h100);
    chk("clr_locked", 32'(locked), 1);
    cc = cc + 4'd3;
    ep = 1;
    push(13'h100, cc);
    send(13'h100, cc, 8'h47, 0, 0, 0, PKT);
    cc++;

    // Misses: bad,good,bad,good then three bad
    for (int j = 0; j < 7; j++) begin
      bit bad;
      bad = (j == 0) || (j == 2) || (j >= 4);
      if (bad) es++;
      if (j < 6) begin
        ep++;
        push(13'h100, cc);
      end
      send(13'h100, cc, bad ? 8'h00 : 8'h47,
           0, 0, 0, PKT);
      cc++;
      if (j == 3) begin
        chk("miss2_se", 32'(sync_err_cnt), 2);
        chk("miss2_locked", 32'(locked), 1);
      end
    end
    chk("miss5_se", 32'(sync_err_cnt), 5);
    chk("miss5_locked", 32'(locked), 0);

    // Relock after loss
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        ep++;
        push(13'h100, cc);
      end
      send(13'h100, cc, 8'h47, 0, 0, 0, PKT);
      cc++;
    end
    chk("relock", 32'(locked), 1);

    // Reset mid-packet, then re-hunt
    ep++;
    push(13'h100, cc);
    send(13'h100, cc, 8'h47, 0, 0, 0, 50);
    cc++;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    step();
    step();
    rst_n = 1'b1;
    ep = 0; ee = 0; es = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        ep++;
        push(13'h100, cc);
      end
      send(13'h100, cc, 8'h47, 0, 0, 0, PKT);
      cc++;
      if (k == 1)
        chk("rehunt_pre", 32'(locked), 0);
    end
    chk("rehunt_lock", 32'(locked), 1);

    repeat (5) step();
    chk("sb_empty", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
